fifo_pkt_arb: RTL
=================

FIFO_PKT_ARB -- requirements
Module: fifo_pkt_arb

Interface
REQ-001 The block SHALL provide parameter DW, default 32, giving the data word width.
REQ-002 The block SHALL provide parameter CNTSHIFT, default 0, giving the bit position of the header count field.
REQ-003 The block SHALL provide parameter CNTMASK, default 7, the mask applied to (header >> CNTSHIFT) to extract the count code.
REQ-004 The block SHALL have the following ports. Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  input  1  clock; all state changes on its rising edge
- rst_i  input  1  synchronous active-high reset
- f1_rd_data_i  input  DW  source 1 FIFO head word, first-word-fall-through, valid while f1_empty_i=0
- f1_empty_i  input  1  source 1 FIFO empty
- f1_rd_en_o  output  1  source 1 pop strobe
- f2_rd_data_i  input  DW  source 2 FIFO head word, first-word-fall-through
- f2_empty_i  input  1  source 2 FIFO empty
- f2_rd_en_o  output  1  source 2 pop strobe
- wr_data_o  output  DW  merged output word
- wr_en_o  output  1  output FIFO write strobe
- full_i  input  1  output FIFO full
- grant_o  output  2  one-hot current grant (bit0=f1, bit1=f2), 0 when idle
- pkt_done_o  output  1  one-cycle pulse on the last word of a packet

Function
REQ-005 Packet format SHALL be: one header word followed by N payload words, N decoded from code=(header>>CNTSHIFT)&CNTMASK: 0->0, 1->1, 2->2, 3->4, 4->8, any other code->0.
REQ-006 The block SHALL forward whole packets; words of packets from f1 and f2 SHALL never interleave on the output.
REQ-007 The FSM SHALL have states IDLE, HDR, PAY.
REQ-008 IDLE: if exactly one source is non-empty, grant it; if both are non-empty, grant the source not granted last (round-robin); if neither is non-empty, stay in IDLE; on a grant, go to HDR next cycle.
REQ-009 Grant SHALL be registered; the first word of a packet SHALL transfer no earlier than the cycle after the IDLE arbitration cycle.
REQ-010 Transfer condition: state in {HDR, PAY} and granted source not empty and full_i=0; in that cycle wr_en_o=1, the granted rd_en_o=1, and wr_data_o equals the granted source's rd_data; the same-cycle (combinational) relationship is intended.
REQ-011 When the transfer condition is false, wr_en_o, f1_rd_en_o and f2_rd_en_o SHALL all be 0; wr_data_o is don't-care.
REQ-012 HDR: on transfer, decode N; N=0 -> pulse pkt_done_o and go to IDLE; otherwise load the 4-bit remaining counter with N and go to PAY; without a transfer, stay in HDR.
REQ-013 PAY: each transfer decrements the remaining counter; a transfer with remaining=1 SHALL pulse pkt_done_o and go to IDLE; stalls from empty or full hold all state.
REQ-014 The last-granted register SHALL update when a grant is issued in IDLE.
REQ-015 grant_o SHALL be 2'b00 in IDLE and SHALL be the held one-hot grant in HDR and PAY.
REQ-016 Minimum packet spacing SHALL be one IDLE cycle between the last word of one packet and the header of the next.
REQ-017 The non-granted source's rd_en SHALL remain 0 for the whole packet, regardless of its empty state.

Reset
REQ-018 While rst_i=1 at a clock edge, the next state SHALL be: FSM=IDLE, remaining counter=0, last-granted=f2 (so f1 wins the first tie).
REQ-019 While rst_i=1, wr_en_o, f1_rd_en_o, f2_rd_en_o and pkt_done_o SHALL be 0 combinationally, and grant_o SHALL be 0.
REQ-020 Reset asserted mid-packet SHALL abandon the packet; no further words of it SHALL be popped until a new arbitration.

Verification
REQ-021 Single f1 packet, header code 3, full_i=0: 1 IDLE cycle, then 5 consecutive writes in the same order; pkt_done_o is asserted on the 5th write.
REQ-022 Both sources hold code-0 headers after reset: output order is f1, f2, f1, f2...; grant_o alternates 01/10 with one IDLE cycle between them.
REQ-023 f1 packet code 4 (8 payload words), f2 becomes non-empty mid-packet: all 9 f1 words are output before any f2 word; f2_rd_en_o stays 0 throughout.
REQ-024 full_i held high for 3 cycles during PAY with remaining=2: no writes or pops during those cycles; after release, 2 writes follow; counter and data are unchanged.
REQ-025 Header code 7 (undefined): treated as N=0; 1 write with pkt_done_o; next word is arbitrated as a new header.
REQ-026 rst_i is pulsed for 1 cycle after the 3rd word of a code-3 packet: all strobes are 0 that cycle; next cycle is IDLE and the next word popped from f1 is treated as a header.

Source files
------------

// File: rtl/fifo_pkt_arb.sv
`default_nettype none
// ============================================================================
// fifo_pkt_arb : merges whole packets from two FWFT FIFOs, round-robin grant
// Rev 1.0
// ============================================================================
module fifo_pkt_arb #(
  parameter int DW       = 32,
  parameter int CNTSHIFT = 0,
  parameter int CNTMASK  = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] f1_rd_data_i,
  input  logic          f1_empty_i,
  output logic          f1_rd_en_o,
  input  logic [DW-1:0] f2_rd_data_i,
  input  logic          f2_empty_i,
  output logic          f2_rd_en_o,
  output logic [DW-1:0] wr_data_o,
  output logic          wr_en_o,
  input  logic          full_i,
  output logic [1:0]    grant_o,
  output logic          pkt_done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_f2_q, last_f2_d;
  logic [3:0]    rem_q, rem_d;
  logic          pkt_done;
  logic          src_empty;
  logic          xfer;
  logic [DW-1:0] src_data;
  logic [DW-1:0] code;
  logic [3:0]    hdr_len;

  assign src_data  = grant_q[1] ? f2_rd_data_i : f1_rd_data_i;
  assign src_empty = grant_q[1] ? f2_empty_i : (grant_q[0] ? f1_empty_i : 1'b1);
  // Reset gates the strobes combinationally so nothing is popped in the reset cycle.
  assign xfer      = !rst_i && (state_q != IDLE) && !src_empty && !full_i;
  assign code      = (src_data >> CNTSHIFT) & DW'(CNTMASK);

  always_comb begin
    hdr_len = 4'd0;
    if (code == DW'(1)) begin
      hdr_len = 4'd1;
    end else if (code == DW'(2)) begin
      hdr_len = 4'd2;
    end else if (code == DW'(3)) begin
      hdr_len = 4'd4;
    end else if (code == DW'(4)) begin
      hdr_len = 4'd8;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_f2_d = last_f2_q;
    rem_d     = rem_q;
    pkt_done  = 1'b0;
    case (state_q)
      IDLE: begin
        // f1 wins when alone, or on a tie when f2 was served last.
        if (!f1_empty_i && (f2_empty_i || last_f2_q)) begin
          grant_d   = 2'b01;
          last_f2_d = 1'b0;
          state_d   = HDR;
        end else if (!f2_empty_i) begin
          grant_d   = 2'b10;
          last_f2_d = 1'b1;
          state_d   = HDR;
        end
      end
      HDR: begin
        if (xfer) begin
          if (hdr_len == 4'd0) begin
            pkt_done = 1'b1;
            grant_d  = 2'b00;
            state_d  = IDLE;
          end else begin
            rem_d   = hdr_len;
            state_d = PAY;
          end
        end
      end
      PAY: begin
        if (xfer) begin
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            pkt_done = 1'b1;
            grant_d  = 2'b00;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_f2_q <= 1'b1;
      rem_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_f2_q <= last_f2_d;
      rem_q     <= rem_d;
    end
  end

  assign wr_en_o    = xfer;
  assign f1_rd_en_o = xfer && grant_q[0];
  assign f2_rd_en_o = xfer && grant_q[1];
  assign wr_data_o  = src_data;
  assign pkt_done_o = pkt_done;
  assign grant_o    = (rst_i || state_q == IDLE) ? 2'b00 : grant_q;

endmodule
`default_nettype wire
